// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Y86-64 instruction encoder. This is the write side of fetch-stage decode.
//   The block accepts one decoded instruction {icode, ifun, rA, rB, valC} on
//   each valid/ready handshake. It then writes the encoded instruction into a
//   byte-wide instruction memory, one byte per clock. The resulting image
//   decodes back bit-exactly in fetch, with valP = PC + len.
//
//   Encoding:
//     byte 0             {icode, ifun}
//     byte 1             {rA, rB}         only for icode 2,3,4,5,6,A,B
//     next 8 bytes       valC, LSB first  only for icode 3,4,5,7,8
//     len = 1, 2, 9 or 10
//
// Ports
//   clk, rst        clock (rising edge); asynchronous active-high reset
//   in_valid/ready  instruction handshake (accepted when both are high at posedge)
//   in_icode/ifun   instruction and function codes
//   in_rA/in_rB     register specifiers
//   in_valC         64-bit constant word
//   load_pc         loads the write pointer from load_addr (IDLE only, wins over in_valid)
//   load_addr       new write pointer
//   wr_en/addr/data registered byte write port
//   done            pulse coincident with the last byte of an instruction
//   err             pulse after an accepted icode >= 4'hC (nothing written)
//   next_pc         write pointer (address of the next instruction byte)
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [3:0]        in_rA,
    input  logic [3:0]        in_rB,
    input  logic [63:0]       in_valC,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] next_pc
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_reg;
    logic [3:0] idx_reg;
    logic [3:0] cnt_reg;
    logic [7:0] buf_reg [10];

    logic [7:0] pack [10];
    logic       need_regids;
    logic       need_valc;
    logic       illegal;
    logic       accept;
    logic [3:0] len;

    // Classify the instruction from its icode.
    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (in_icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            4'h7, 4'h8: need_valc = 1'b1;
            default: ;
        endcase
    end

    assign illegal  = (in_icode >= 4'hC);
    assign len      = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
    // This is combinational so that it drops immediately on reset or load_pc.
    assign in_ready = (state_reg == IDLE) & ~load_pc & ~rst;
    assign accept   = in_valid & in_ready;

    // Place each byte at its final position. When there is no regid byte,
    // valC starts one byte earlier. Positions past len are never emitted.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_pack
            if (gi == 0) begin : g_b0
                assign pack[gi] = {in_icode, in_ifun};
            end else if (gi == 1) begin : g_b1
                assign pack[gi] = need_regids ? {in_rA, in_rB} : in_valC[7:0];
            end else if (gi == 9) begin : g_b9
                assign pack[gi] = in_valC[63:56];
            end else begin : g_bc
                assign pack[gi] = need_regids ? in_valC[8*(gi-2) +: 8]
                                              : in_valC[8*(gi-1) +: 8];
            end

            // The buffer holds the instruction, so in_* may change during EMIT.
            always_ff @(posedge clk) begin
                if (accept && !illegal) begin
                    buf_reg[gi] <= pack[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            next_pc   <= BASE_ADDR;
            wr_en     <= 1'b0;
            wr_addr   <= BASE_ADDR;
            wr_data   <= 8'h00;
            done      <= 1'b0;
            err       <= 1'b0;
            idx_reg   <= 4'd0;
            cnt_reg   <= 4'd0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_pc) begin
                        next_pc <= load_addr;
                    end else if (accept) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            idx_reg   <= 4'd0;
                            cnt_reg   <= len;
                            state_reg <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    wr_en   <= 1'b1;
                    wr_addr <= next_pc;
                    wr_data <= buf_reg[idx_reg];
                    // The write pointer wraps naturally at 2^ADDR_W.
                    next_pc <= next_pc + ADDR_W'(1);
                    idx_reg <= idx_reg + 4'd1;
                    if (idx_reg == cnt_reg - 4'd1) begin
                        done      <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
